// File: rtl/frame_l2_in.sv
// -----------------------------------------------------------------------------
// frame_l2_in
//
// Nibble-wide (MII style) receive front end for layer-2 frames. It hunts for a
// preamble of 0x5 nibbles closed by an SFD nibble 0xD, assembles the following
// nibbles into bytes (low nibble first), runs a reflected CRC-32 over every
// byte and forwards the payload with the 4 FCS bytes stripped. A 5-byte delay
// line holds back the most recent bytes so that the FCS never leaves the block
// and the last payload byte can be tagged with EoFOut and the CRC verdict.
//
// Ports
//   Clk       in   single clock, rising edge
//   Rst       in   asynchronous, active-high reset
//   LINK_UP   in   link status; low forces the receiver back to IDLE
//   ValIn     in   receive nibble valid
//   DataIn    in   [3:0] receive nibble
//   ValOut    out  payload byte strobe, one cycle per byte
//   SoFOut    out  first payload byte (qualified by ValOut)
//   EoFOut    out  last payload byte (qualified by ValOut)
//   ErrOut    out  frame status with EoFOut, 1 = bad frame
//   DataOut   out  [7:0] payload byte
//   StateOut  out  [1:0] current receiver state (0 IDLE, 1 PRE, 2 DATA, 3 DROP)
//
// Handshake: there is no back-pressure. ValIn marks DataIn as a live nibble on
// every rising edge where it is high; ValOut marks DataOut (and SoF/EoF/Err)
// as a live beat for exactly that one cycle, and the sink must accept it.
// All of SoFOut, EoFOut, ErrOut and DataOut are forced to 0 when ValOut is 0.
// -----------------------------------------------------------------------------
module frame_l2_in #(
  parameter int MIN_PRE = 2,
  parameter int MAX_LEN = 1522
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       LINK_UP,
  input  logic       ValIn,
  input  logic [3:0] DataIn,
  output logic       ValOut,
  output logic       SoFOut,
  output logic       EoFOut,
  output logic       ErrOut,
  output logic [7:0] DataOut,
  output logic [1:0] StateOut
);

  // Byte counter must be able to hold MAX_LEN and compare against 5.
  localparam int CW = (MAX_LEN < 8) ? 4 : $clog2(MAX_LEN + 1);

  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
  // Register contents after a frame with a correct FCS has been run through.
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

  localparam logic [3:0]  NIB_PRE = 4'h5;
  localparam logic [3:0]  NIB_SFD = 4'hD;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PRE  = 2'd1,
    S_DATA = 2'd2,
    S_DROP = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t          state_q;
  logic [3:0]      pre_cnt_q;     // preamble nibbles seen, saturating at 15
  logic [31:0]     crc_q;
  logic            nib_hi_q;      // 1: low nibble captured, waiting for high
  logic [3:0]      low_nib_q;
  logic [CW-1:0]   byte_cnt_q;    // bytes completed since the SFD
  logic [7:0]      dl_q [0:4];    // dl_q[0] newest byte, dl_q[4] oldest
  logic            sof_sent_q;    // SoF already emitted for the current frame
  // Set once ValIn has been seen low in IDLE. Keeps the receiver from locking
  // onto the tail of a frame that was already streaming when reset released
  // or when the link came back.
  logic            armed_q;

  logic            val_q;
  logic            sof_q;
  logic            eof_q;
  logic            err_q;
  logic [7:0]      data_q;

  // ---------------------------------------------------------------------------
  // Next-value helpers for the byte path
  // ---------------------------------------------------------------------------
  logic [7:0]      byte_d;
  logic [31:0]     crc_d;
  logic [CW-1:0]   byte_cnt_d;
  logic            crc_bad_d;

  // One byte of the reflected CRC-32, LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] crc,
                                           input logic [7:0]  data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int b = 0; b < 8; b++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  assign byte_d     = {DataIn, low_nib_q};
  assign crc_d      = crc_byte(crc_q, byte_d);
  assign byte_cnt_d = byte_cnt_q + CW'(1);
  assign crc_bad_d  = (crc_q != CRC_RESIDUE);

  // ---------------------------------------------------------------------------
  // Receiver FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q    <= S_IDLE;
      pre_cnt_q  <= '0;
      crc_q      <= CRC_INIT;
      nib_hi_q   <= 1'b0;
      low_nib_q  <= '0;
      byte_cnt_q <= '0;
      for (int i = 0; i < 5; i++) dl_q[i] <= '0;
      sof_sent_q <= 1'b0;
      armed_q    <= 1'b0;
      val_q      <= 1'b0;
      sof_q      <= 1'b0;
      eof_q      <= 1'b0;
      err_q      <= 1'b0;
      data_q     <= '0;
    end else begin
      // Output beat defaults: nothing emitted unless a branch below says so.
      val_q  <= 1'b0;
      sof_q  <= 1'b0;
      eof_q  <= 1'b0;
      err_q  <= 1'b0;
      data_q <= '0;

      if (!LINK_UP) begin
        // An open frame (SoF already out) must still be closed with an
        // error beat so downstream sees a matched SoF/EoF pair.
        if (state_q == S_DATA && sof_sent_q) begin
          val_q <= 1'b1;
          eof_q <= 1'b1;
          err_q <= 1'b1;
        end
        state_q    <= S_IDLE;
        sof_sent_q <= 1'b0;
        armed_q    <= 1'b0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (!ValIn) begin
              armed_q <= 1'b1;
            end else if (armed_q && DataIn == NIB_PRE) begin
              state_q   <= S_PRE;
              pre_cnt_q <= 4'd1;
            end
          end

          S_PRE: begin
            if (!ValIn) begin
              state_q <= S_IDLE;
            end else if (DataIn == NIB_PRE) begin
              if (pre_cnt_q != 4'hF) pre_cnt_q <= pre_cnt_q + 4'd1;
            end else if (DataIn == NIB_SFD && pre_cnt_q >= 4'(MIN_PRE)) begin
              state_q    <= S_DATA;
              crc_q      <= CRC_INIT;
              nib_hi_q   <= 1'b0;
              byte_cnt_q <= '0;
              for (int i = 0; i < 5; i++) dl_q[i] <= '0;
              sof_sent_q <= 1'b0;
            end else begin
              state_q <= S_DROP;
            end
          end

          S_DATA: begin
            if (!ValIn) begin
              // End of frame. The delay line holds bytes N..N-4, so the
              // oldest entry is the last payload byte; the rest is FCS.
              if (byte_cnt_q >= CW'(5)) begin
                val_q  <= 1'b1;
                sof_q  <= !sof_sent_q;
                eof_q  <= 1'b1;
                err_q  <= crc_bad_d || nib_hi_q;
                data_q <= dl_q[4];
              end
              state_q    <= S_IDLE;
              sof_sent_q <= 1'b0;
            end else if (!nib_hi_q) begin
              low_nib_q <= DataIn;
              nib_hi_q  <= 1'b1;
            end else begin
              nib_hi_q <= 1'b0;
              if (byte_cnt_q == CW'(MAX_LEN)) begin
                // Oversize: this byte would exceed MAX_LEN.
                if (sof_sent_q) begin
                  val_q <= 1'b1;
                  eof_q <= 1'b1;
                  err_q <= 1'b1;
                end
                state_q    <= S_DROP;
                sof_sent_q <= 1'b0;
              end else begin
                crc_q      <= crc_d;
                byte_cnt_q <= byte_cnt_d;
                for (int i = 4; i > 0; i--) dl_q[i] <= dl_q[i-1];
                dl_q[0] <= byte_d;
                // Five bytes already buffered: the oldest one is known not
                // to be FCS and can be released.
                if (byte_cnt_q >= CW'(5)) begin
                  val_q      <= 1'b1;
                  sof_q      <= !sof_sent_q;
                  data_q     <= dl_q[4];
                  sof_sent_q <= 1'b1;
                end
              end
            end
          end

          S_DROP: begin
            if (!ValIn) state_q <= S_IDLE;
          end

          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign ValOut   = val_q;
  assign SoFOut   = sof_q;
  assign EoFOut   = eof_q;
  assign ErrOut   = err_q;
  assign DataOut  = data_q;
  assign StateOut = state_q;

endmodule

// File: tb/tb_frame_l2_in.sv
// -----------------------------------------------------------------------------
// tb_frame_l2_in
//
// Bench for frame_l2_in with default parameters (MIN_PRE=2, MAX_LEN=1522).
// Frames are built in a byte queue with a freshly computed FCS; the expected
// payload beats are pushed to exp_q before the nibbles are driven, and a
// negedge monitor pops and compares every ValOut beat.
// -----------------------------------------------------------------------------
module tb_frame_l2_in;

  logic       Clk;
  logic       Rst;
  logic       LINK_UP;
  logic       ValIn;
  logic [3:0] DataIn;
  logic       ValOut;
  logic       SoFOut;
  logic       EoFOut;
  logic       ErrOut;
  logic [7:0] DataOut;
  logic [1:0] StateOut;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DROP = 2'd3;

  frame_l2_in #(.MIN_PRE(2), .MAX_LEN(1522)) dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .LINK_UP (LINK_UP),
    .ValIn   (ValIn),
    .DataIn  (DataIn),
    .ValOut  (ValOut),
    .SoFOut  (SoFOut),
    .EoFOut  (EoFOut),
    .ErrOut  (ErrOut),
    .DataOut (DataOut),
    .StateOut(StateOut)
  );

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Scoreboard: entries are {sof, eof, err, data}
  // ---------------------------------------------------------------------------
  logic [10:0] exp_q[$];
  logic [7:0]  frm[$];
  int n_checks = 0;
  int n_pass   = 0;
  int last_beat_cyc = -100;

  always @(negedge Clk) begin
    if (!Rst) begin
      if (ValOut) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL beat_unexpected: got beat sof=%0b eof=%0b err=%0b data=%02h, required no beat",
                   SoFOut, EoFOut, ErrOut, DataOut);
        end else begin
          logic [10:0] e;
          e = exp_q.pop_front();
          if ({SoFOut, EoFOut, ErrOut, DataOut} !== e)
            $display("FAIL beat_value: got sof=%0b eof=%0b err=%0b data=%02h, required sof=%0b eof=%0b err=%0b data=%02h",
                     SoFOut, EoFOut, ErrOut, DataOut, e[10], e[9], e[8], e[7:0]);
          else
            n_pass++;
        end
        // Mid-frame beats come one per byte, i.e. every 2 cycles.
        if (!SoFOut && !EoFOut) begin
          n_checks++;
          if (cyc - last_beat_cyc !== 2)
            $display("FAIL beat_gap: got %0d cycles, required 2", cyc - last_beat_cyc);
          else
            n_pass++;
        end
        last_beat_cyc = cyc;
      end else begin
        n_checks++;
        if ({SoFOut, EoFOut, ErrOut, DataOut} !== 11'h0)
          $display("FAIL idle_outputs: got sof=%0b eof=%0b err=%0b data=%02h with ValOut=0, required all 0",
                   SoFOut, EoFOut, ErrOut, DataOut);
        else
          n_pass++;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Frame construction and driver tasks
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] crc_upd(input logic [31:0] c_in, input logic [7:0] b);
    logic [31:0] c;
    c = c_in ^ {24'h0, b};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  // Payload of plen bytes (1,2,3,... or random) followed by the FCS.
  task automatic build_frame(input int plen, input bit rnd);
    logic [31:0] crc;
    logic [31:0] fcs;
    frm.delete();
    for (int i = 0; i < plen; i++)
      frm.push_back(rnd ? 8'($urandom_range(0, 255)) : 8'(i + 1));
    crc = 32'hFFFFFFFF;
    foreach (frm[i]) crc = crc_upd(crc, frm[i]);
    fcs = ~crc;
    frm.push_back(fcs[7:0]);
    frm.push_back(fcs[15:8]);
    frm.push_back(fcs[23:16]);
    frm.push_back(fcs[31:24]);
  endtask

  // Expected beats: bytes 1..N-4 of frm, SoF on the first, EoF+err on the last.
  task automatic expect_frame(input bit err);
    int n;
    n = frm.size();
    if (n >= 5) begin
      for (int i = 0; i <= n - 5; i++)
        exp_q.push_back({(i == 0), (i == n - 5), ((i == n - 5) && err), frm[i]});
    end
  endtask

  // Inputs change 1 time unit after a rising edge and are sampled at the next.
  task automatic drive_nib(input logic v, input logic [3:0] d);
    ValIn  = v;
    DataIn = d;
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) drive_nib(1'b0, 4'h0);
  endtask

  task automatic drive_header(input int npre, input logic [3:0] sfd);
    for (int i = 0; i < npre; i++) drive_nib(1'b1, 4'h5);
    drive_nib(1'b1, sfd);
  endtask

  task automatic drive_bytes(input int first, input int count);
    for (int i = first; i < first + count; i++) begin
      drive_nib(1'b1, frm[i][3:0]);
      drive_nib(1'b1, frm[i][7:4]);
    end
  endtask

  task automatic drive_frame(input int npre, input logic [3:0] sfd, input bit extra_nib);
    drive_header(npre, sfd);
    drive_bytes(0, frm.size());
    if (extra_nib) drive_nib(1'b1, 4'hA);
    idle_cycles(4);
  endtask

  // Bounded drain, then every expected beat must have been consumed.
  task automatic drain_check(input string name);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle_cycles(1);
    n_checks++;
    if (exp_q.size() !== 0)
      $display("FAIL %s_drain: got %0d beats still expected, required 0", name, exp_q.size());
    else
      n_pass++;
  endtask

  task automatic check_state(input string name, input logic [1:0] req);
    n_checks++;
    if (StateOut !== req)
      $display("FAIL %s_state: got %0d, required %0d", name, StateOut, req);
    else
      n_pass++;
  endtask

  task automatic good_frame(input string name);
    build_frame(60, 1'b0);
    expect_frame(1'b0);
    drive_frame(15, 4'hD, 1'b0);
    drain_check(name);
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset;
    Rst = 1'b1; LINK_UP = 1'b1; ValIn = 1'b0; DataIn = 4'h0;
    #1;
    n_checks++;
    if ({ValOut, SoFOut, EoFOut, ErrOut, DataOut} !== 12'h0)
      $display("FAIL reset_outputs: got %03h, required 000", {ValOut, SoFOut, EoFOut, ErrOut, DataOut});
    else n_pass++;
    check_state("reset", ST_IDLE);
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    Rst = 1'b0;
    idle_cycles(3);
    check_state("after_reset", ST_IDLE);
  endtask

  task automatic test_good;
    good_frame("good");
    check_state("good_end", ST_IDLE);
  endtask

  task automatic test_bad_fcs;
    build_frame(60, 1'b0);
    expect_frame(1'b1);
    frm[60][0] = ~frm[60][0];
    drive_frame(15, 4'hD, 1'b0);
    drain_check("bad_fcs");
  endtask

  task automatic test_extra_nibble;
    build_frame(60, 1'b0);
    expect_frame(1'b1);
    drive_frame(15, 4'hD, 1'b1);
    drain_check("extra_nib");
  endtask

  task automatic test_runt;
    build_frame(0, 1'b0);           // 4 bytes after SFD: FCS only
    drive_frame(15, 4'hD, 1'b0);
    drain_check("runt");
    check_state("runt_end", ST_IDLE);
    good_frame("after_runt");
  endtask

  task automatic test_bad_preamble;
    drive_nib(1'b1, 4'h5);
    drive_nib(1'b1, 4'h5);
    drive_nib(1'b1, 4'hA);
    check_state("bad_pre", ST_DROP);
    build_frame(20, 1'b1);
    drive_nib(1'b1, 4'hD);
    drive_bytes(0, frm.size());
    idle_cycles(4);
    drain_check("bad_pre");
    good_frame("after_bad_pre");
  endtask

  task automatic test_min_preamble;
    // One preamble nibble is below MIN_PRE: dropped.
    build_frame(10, 1'b1);
    drive_frame(1, 4'hD, 1'b0);
    drain_check("pre_short");
    // Exactly MIN_PRE nibbles is enough.
    build_frame(10, 1'b1);
    expect_frame(1'b0);
    drive_frame(2, 4'hD, 1'b0);
    drain_check("pre_min");
  endtask

  task automatic test_single_byte;
    build_frame(1, 1'b1);           // N = 5: SoF and EoF on the same beat
    expect_frame(1'b0);
    drive_frame(7, 4'hD, 1'b0);
    drain_check("single_byte");
  endtask

  task automatic test_random_frames;
    for (int f = 0; f < 4; f++) begin
      build_frame($urandom_range(2, 40), 1'b1);
      expect_frame(1'b0);
      drive_frame($urandom_range(2, 15), 4'hD, 1'b0);
      drain_check("random");
    end
  endtask

  task automatic test_link_down;
    build_frame(60, 1'b0);
    // Bytes 1..10 come out by the time byte 15 completes; then the link drops.
    for (int i = 0; i < 10; i++) exp_q.push_back({1'b0 | (i == 0), 2'b00, frm[i]});
    exp_q.push_back({3'b011, 8'h00});
    drive_header(15, 4'hD);
    drive_bytes(0, 15);
    LINK_UP = 1'b0;
    drive_nib(1'b1, frm[15][3:0]);
    check_state("link_down", ST_IDLE);
    drive_nib(1'b0, 4'h0);
    LINK_UP = 1'b1;
    idle_cycles(3);
    drain_check("link_down");
    good_frame("after_link");
  endtask

  task automatic test_reset_mid_frame;
    build_frame(60, 1'b0);
    for (int i = 0; i < 3; i++) exp_q.push_back({(i == 0), 2'b00, frm[i]});
    drive_header(15, 4'hD);
    drive_bytes(0, 8);              // beat for byte 3 is now on the outputs
    #5;                             // past the monitor's negedge sample
    Rst = 1'b1;
    #1;
    n_checks++;
    if ({ValOut, SoFOut, EoFOut, ErrOut, DataOut} !== 12'h0)
      $display("FAIL rst_mid_outputs: got %03h, required 000", {ValOut, SoFOut, EoFOut, ErrOut, DataOut});
    else n_pass++;
    @(posedge Clk); #1;
    drive_nib(1'b1, 4'h5);
    Rst = 1'b0;
    // Still-running frame that looks like a fresh preamble: must be ignored.
    drive_nib(1'b1, 4'h5);
    drive_nib(1'b1, 4'h5);
    drive_nib(1'b1, 4'h5);
    drive_nib(1'b1, 4'hD);
    for (int i = 0; i < 16; i++) drive_nib(1'b1, 4'($urandom_range(0, 15)));
    idle_cycles(3);
    drain_check("rst_mid");
    good_frame("after_rst");
  endtask

  task automatic test_oversize;
    build_frame(1523, 1'b1);
    for (int i = 0; i < 1517; i++) exp_q.push_back({(i == 0), 2'b00, frm[i]});
    exp_q.push_back({3'b011, 8'h00});
    drive_header(7, 4'hD);
    drive_bytes(0, 1523);
    check_state("oversize", ST_DROP);
    drive_bytes(1523, 4);           // trailing bytes stay in DROP
    idle_cycles(4);
    drain_check("oversize");
    good_frame("after_oversize");
  endtask

  initial begin
    test_reset();
    test_good();
    test_bad_fcs();
    test_extra_nibble();
    test_runt();
    test_bad_preamble();
    test_min_preamble();
    test_single_byte();
    test_random_frames();
    test_link_down();
    test_reset_mid_frame();
    test_oversize();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/frame_l2_in.md
FRAME_L2_IN -- requirements
Module: frame_l2_in

Interface
REQ-001 SHALL have parameter MIN_PRE, default 2, meaning the minimum count of 0x5 preamble nibbles required before the SFD nibble.
REQ-002 SHALL have parameter MAX_LEN, default 1522, meaning the maximum frame length in bytes after the SFD, FCS included.
REQ-003 SHALL have port Clk  in  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port Rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port LINK_UP  in  1  link status, level-sensitive.
REQ-006 SHALL have port ValIn  in  1  receive nibble valid.
REQ-007 SHALL have port DataIn  in  4  receive nibble, one per Clk, low nibble of each byte first.
REQ-008 SHALL have port ValOut  out  1  payload byte strobe, one cycle per byte.
REQ-009 SHALL have port SoFOut  out  1  first payload byte, qualified by ValOut.
REQ-010 SHALL have port EoFOut  out  1  last payload byte, qualified by ValOut.
REQ-011 SHALL have port ErrOut  out  1  frame status, valid only with EoFOut; 1 = bad.
REQ-012 SHALL have port DataOut  out  8  payload byte.

Function
REQ-013 SHALL implement states IDLE, PRE, DATA and DROP.
REQ-014 IDLE SHALL go to PRE on ValIn=1 with DataIn=0x5 (preamble count=1); it SHALL ignore any other input.
REQ-015 In PRE: 0x5 increments the count (saturating at 15); 0xD with count>=MIN_PRE goes to DATA; any other nibble, or 0xD with count<MIN_PRE, goes to DROP; ValIn=0 goes to IDLE.
REQ-016 DROP SHALL wait for ValIn=0, then go to IDLE, producing no output.
REQ-017 On entering DATA: CRC SHALL be set to 0xFFFFFFFF, the nibble phase to low, the byte count to 0, and the 5-byte delay line emptied.
REQ-018 In DATA, each pair of nibbles (low, then high) SHALL form one byte.
REQ-019 Each byte SHALL be fed to a reflected CRC-32 (poly 0xEDB88320) and shifted into the 5-byte delay line.
REQ-020 When byte k completes and k>=6, byte k-5 SHALL be emitted (ValOut=1, DataOut=byte) in the next cycle.
REQ-021 SoFOut SHALL be 1 on the first emitted byte only.
REQ-022 On the first ValIn=0 in DATA with byte count N>=5, byte N-4 SHALL be emitted next cycle with EoFOut=1; the 4 FCS bytes SHALL never be emitted.
REQ-023 When N=5, the single payload byte SHALL carry SoFOut=1 and EoFOut=1 together.
REQ-024 ErrOut at EoF SHALL be 1 if the CRC register is not 0xDEBB20E3 after byte N, or if a half byte is pending (odd nibble count); otherwise 0.
REQ-025 When N<5 (runt), no ValOut SHALL occur, and the block SHALL return to IDLE.
REQ-026 When the byte count would exceed MAX_LEN: if SoF was already emitted, one beat ValOut=1, EoFOut=1, ErrOut=1, DataOut=0x00 SHALL be emitted, then go to DROP; otherwise go to DROP silently.
REQ-027 LINK_UP=0 SHALL force IDLE from any state.
REQ-028 If LINK_UP drops mid-frame after SoF, the same terminating error beat as REQ-026 SHALL be emitted next cycle.
REQ-029 All outputs SHALL be registered; in steady DATA, ValOut SHALL pulse once every 2 cycles.
REQ-030 SoFOut, EoFOut, ErrOut and DataOut SHALL be 0 whenever ValOut=0.
REQ-031 Every SoF SHALL be matched by exactly one EoF before the next SoF.

Reset
REQ-032 Rst=1 SHALL asynchronously clear all outputs to 0, set the state to IDLE, CRC to 0xFFFFFFFF, and all counters and the delay line to 0.
REQ-033 Reset mid-frame SHALL emit no terminating beat; the first frame after Rst release SHALL start from IDLE.
REQ-034 A frame already in progress when Rst falls SHALL be ignored until ValIn=0 and a new preamble arrive.

Verification
REQ-035 Good frame: 15x 0x5, 0xD, payload 0x01..0x3C (60 bytes), correct FCS -> 60 ValOut pulses 2 cycles apart, SoF on 0x01, EoF on 0x3C, ErrOut=0, no FCS bytes out.
REQ-036 Same frame with FCS bit 0 flipped -> identical data, EoF on 0x3C with ErrOut=1.
REQ-037 Good frame plus one extra nibble 0xA before ValIn falls -> EoF on 0x3C, ErrOut=1.
REQ-038 4-byte frame after SFD -> no ValOut; a following good frame is received correctly.
REQ-039 Preamble 0x5, 0x5, 0xA, then data -> no output (DROP); a following good frame is received correctly.
REQ-040 LINK_UP=0 after 10 payload bytes emitted -> next cycle DataOut=0x00 with ValOut=EoFOut=ErrOut=1, then IDLE; Rst mid-frame -> outputs 0 immediately, no EoF beat.
